kirby_action_ctrl: RTL and testbench
====================================

// Module: kirby_action_ctrl
// PURPOSE
//  Sequences Kirby's movement and action state once per video frame. Decodes keycode into
//  walk/jump/float/inhale actions, applies gravity and screen clamping, and drives the
//  position, facing, action and animation-frame outputs consumed by the Kirby draw/sprite logic.
//  Sits between the keyboard keycode path and the per-pixel Kirby renderer.
// PARAMETERS
//  X_MIN 10'd203 / X_MAX 10'd436 : horizontal play-field bounds (left edge / right edge)
//  Y_MIN 10'd152 / Y_MAX 10'd327 : vertical play-field bounds (top / ground line)
//  SIZE 10'd4 : Kirby half-extent; centre clamped to [X_MIN+SIZE, X_MAX-SIZE] and [Y_MIN+SIZE, Y_MAX-SIZE]
//  X_STEP 10'd1 : walk speed, pixels/frame
//  JUMP_V -10'sd6 : initial vy on jump; FLOAT_LIFT -10'sd2 : vy on a float flap
//  MAX_FALL 10'sd4 : vy saturation (downward); FLOAT_FALL 10'sd1 : vy while floating
//  INHALE_MIN 6'd8 : minimum frames spent in INHALE; ANIM_DIV 4'd6 : frames per anim step
// PORTS
//  Clk            in   1   50 MHz system clock
//  Reset          in   1   synchronous, active-high reset
//  frame_clk      in   1   frame strobe (~60 Hz), asynchronous level to Clk domain timing
//  keycode        in   8   current HID keycode (0x00 = none)
//  kirby_x        out  10  Kirby centre X
//  kirby_y        out  10  Kirby centre Y
//  action         out  3   action_t: IDLE, WALK, JUMP, FALL, FLOAT, INHALE
//  facing_left    out  1   1 = sprite mirrored (facing left)
//  anim_frame     out  2   animation sub-frame index within current action
//  inhale_active  out  1   high while action == INHALE (enemy-capture enable)
// BEHAVIOUR
//  Reset: x=320, y=Y_MAX-SIZE, vy=0, action=IDLE, facing_left=0, anim_frame=0, counters=0.
//  Reset takes priority over a tick in the same cycle; mid-air reset snaps to the reset values.
//  Tick: frame_clk rising edge registered (1 Clk); all state updates on the next Clk edge.
//  Latency frame_clk rise -> outputs updated = 2 Clk. Between ticks all outputs hold.
//  Keys (sampled on tick only): A 0x04 left, D 0x07 right, W 0x1A jump/flap, J 0x0D inhale.
//  w_edge = W on this tick and not W on previous tick (previous-tick key register).
//  Transitions (evaluated on tick, priority top-down):
//   IDLE/WALK: J -> INHALE (cnt=0); w_edge -> JUMP (vy=JUMP_V); A/D -> WALK; else IDLE.
//   JUMP: vy>=0 -> FALL; w_edge -> FLOAT.  FALL: w_edge -> FLOAT; grounded -> IDLE.
//   FLOAT: w_edge -> vy=FLOAT_LIFT, else vy=FLOAT_FALL; grounded -> IDLE.
//   INHALE: cnt++ (saturating); exit to IDLE when cnt>=INHALE_MIN and J not held.
//  Horizontal: A/D move x by X_STEP in all states except INHALE (x frozen); A sets
//   facing_left=1, D sets 0; facing unchanged during INHALE.
//  Vertical (JUMP/FALL): y += vy then vy = min(vy+1, MAX_FALL). Signed 10-bit vy; y math in
//   11-bit signed then clamped.
//  Clamps: x limited to bounds (no wrap). y>=Y_MAX-SIZE -> y=Y_MAX-SIZE, vy=0, grounded.
//   y<=Y_MIN+SIZE -> y=Y_MIN+SIZE, vy=0 (ceiling bump, state continues).
//  Walking off is impossible (flat floor); grounded == (y == Y_MAX-SIZE).
//  Anim: divider counts ticks; at ANIM_DIV-1 wraps and anim_frame++ mod 4. Any action change
//   clears divider and anim_frame on the same tick.
//  keycode other than the four keys (or 0x00) = no key.
// STRUCTURE
//  kirby_pkg: action_t enum (3-bit), KEY_A/KEY_D/KEY_W/KEY_J localparams, play-field defaults.
//  Sub-module kirby_frame_tick: frame_clk edge detector -> 1-Clk tick pulse (reusable by
//   enemy and scroll controllers). FSM, physics and anim divider stay in this module.
// TESTING
//  1 Reset, 3 idle ticks -> x=320, y=323, action=IDLE, anim_frame=0, facing_left=0.
//  2 keycode=0x07 for 5 ticks -> x=325, action=WALK, facing_left=0; 0x04 1 tick -> x=324, facing_left=1.
//  3 W edge from ground -> y sequence 317,312,308,305,303,302,302,303... -> FALL -> lands y=323 IDLE vy=0.
//  4 W held through jump -> no FLOAT; release then W again mid-air -> FLOAT, y +1/tick, flap -> -2.
//  5 J held 3 ticks then released -> stays INHALE until tick 8, inhale_active=1, x unchanged with A.
//  6 Walk D 200 ticks -> x saturates 432; Reset asserted same cycle as tick -> reset values win.

Source files
------------

// File: rtl/kirby_pkg.sv
`default_nettype none
// ============================================================================
// Module : kirby_pkg
// Purpose: Shared types and constants for the Kirby controller slice: the
//          action encoding, the four control keycodes and play-field defaults.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package kirby_pkg;

    typedef enum logic [2:0] {
        ACT_IDLE   = 3'd0,
        ACT_WALK   = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_FALL   = 3'd3,
        ACT_FLOAT  = 3'd4,
        ACT_INHALE = 3'd5
    } action_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_J = 8'h0D;

    localparam logic [9:0]        DEF_X_MIN      = 10'd203;
    localparam logic [9:0]        DEF_X_MAX      = 10'd436;
    localparam logic [9:0]        DEF_Y_MIN      = 10'd152;
    localparam logic [9:0]        DEF_Y_MAX      = 10'd327;
    localparam logic [9:0]        DEF_SIZE       = 10'd4;
    localparam logic [9:0]        DEF_X_STEP     = 10'd1;
    localparam logic signed [9:0] DEF_JUMP_V     = -10'sd6;
    localparam logic signed [9:0] DEF_FLOAT_LIFT = -10'sd2;
    localparam logic signed [9:0] DEF_MAX_FALL   = 10'sd4;
    localparam logic signed [9:0] DEF_FLOAT_FALL = 10'sd1;
    localparam logic [5:0]        DEF_INHALE_MIN = 6'd8;
    localparam logic [3:0]        DEF_ANIM_DIV   = 4'd6;
    localparam logic [9:0]        DEF_START_X    = 10'd320;

    // Actions in which the vertical physics step runs.
    function automatic logic is_airborne(input action_t a);
        return (a == ACT_JUMP) || (a == ACT_FALL) || (a == ACT_FLOAT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kirby_frame_tick.sv
`default_nettype none
// ============================================================================
// Module : kirby_frame_tick
// Purpose: Turns the slow frame_clk level into a single-cycle tick pulse,
//          registered one clock after the rising edge is seen.
// Ports  : clk_i       system clock
//          rst_i       synchronous active-high reset
//          frame_clk_i frame strobe level
//          tick_o      one-clock pulse per frame_clk rising edge
// Rev    : 1.0  initial release
// ============================================================================
module kirby_frame_tick (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_clk_i,
    output logic tick_o
);

    logic frame_prev_q;
    logic tick_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_prev_q <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            frame_prev_q <= frame_clk_i;
            tick_q       <= frame_clk_i & ~frame_prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/kirby_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module : kirby_action_ctrl
// Purpose: Per-frame Kirby movement/action sequencer: key decode, action FSM,
//          gravity with screen clamping, facing and animation sub-frame.
// Ports  : clk_i, rst_i       clock, synchronous active-high reset
//          frame_clk_i        frame strobe level
//          keycode_i[7:0]     current HID keycode
//          kirby_x_o/_y_o     Kirby centre position
//          action_o[2:0]      action_t encoding
//          facing_left_o      sprite mirrored
//          anim_frame_o[1:0]  animation sub-frame
//          inhale_active_o    high while action is INHALE
// Rev    : 1.0  initial release
// ============================================================================
module kirby_action_ctrl
    import kirby_pkg::*;
#(
    parameter logic [9:0]        X_MIN      = DEF_X_MIN,
    parameter logic [9:0]        X_MAX      = DEF_X_MAX,
    parameter logic [9:0]        Y_MIN      = DEF_Y_MIN,
    parameter logic [9:0]        Y_MAX      = DEF_Y_MAX,
    parameter logic [9:0]        SIZE       = DEF_SIZE,
    parameter logic [9:0]        X_STEP     = DEF_X_STEP,
    parameter logic signed [9:0] JUMP_V     = DEF_JUMP_V,
    parameter logic signed [9:0] FLOAT_LIFT = DEF_FLOAT_LIFT,
    parameter logic signed [9:0] MAX_FALL   = DEF_MAX_FALL,
    parameter logic signed [9:0] FLOAT_FALL = DEF_FLOAT_FALL,
    parameter logic [5:0]        INHALE_MIN = DEF_INHALE_MIN,
    parameter logic [3:0]        ANIM_DIV   = DEF_ANIM_DIV
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_clk_i,
    input  logic [7:0] keycode_i,
    output logic [9:0] kirby_x_o,
    output logic [9:0] kirby_y_o,
    output logic [2:0] action_o,
    output logic       facing_left_o,
    output logic [1:0] anim_frame_o,
    output logic       inhale_active_o
);

    localparam logic [9:0] c_x_lo     = X_MIN + SIZE;
    localparam logic [9:0] c_x_hi     = X_MAX - SIZE;
    localparam logic [9:0] c_y_top    = Y_MIN + SIZE;
    localparam logic [9:0] c_y_ground = Y_MAX - SIZE;

    logic tick;

    kirby_frame_tick u_frame_tick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .frame_clk_i (frame_clk_i),
        .tick_o      (tick)
    );

    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [9:0] vy_q, vy_d;
    action_t           state_q, state_d;
    logic              facing_q, facing_d;
    logic [1:0]        anim_q, anim_d;
    logic [3:0]        div_q, div_d;
    logic [5:0]        cnt_q, cnt_d, cnt_inc;
    logic              w_prev_q, w_prev_d;

    logic              key_a, key_d, key_w, key_j, w_edge;
    logic signed [9:0] vy_use;
    logic signed [10:0] y_sum;

    assign key_a   = (keycode_i == KEY_A);
    assign key_d   = (keycode_i == KEY_D);
    assign key_w   = (keycode_i == KEY_W);
    assign key_j   = (keycode_i == KEY_J);
    assign w_edge  = key_w & ~w_prev_q;
    assign cnt_inc = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        state_d  = state_q;
        facing_d = facing_q;
        anim_d   = anim_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        w_prev_d = w_prev_q;
        vy_use   = vy_q;
        y_sum    = '0;

        if (tick) begin
            w_prev_d = key_w;

            // Horizontal motion is frozen only while already inhaling.
            if (state_q != ACT_INHALE) begin
                if (key_a) begin
                    facing_d = 1'b1;
                    x_d      = (x_q < c_x_lo + X_STEP) ? c_x_lo : x_q - X_STEP;
                end else if (key_d) begin
                    facing_d = 1'b0;
                    x_d      = (x_q + X_STEP > c_x_hi) ? c_x_hi : x_q + X_STEP;
                end
            end

            case (state_q)
                ACT_IDLE, ACT_WALK: begin
                    if (key_j) begin
                        state_d = ACT_INHALE;
                        cnt_d   = 6'd0;
                    end else if (w_edge) begin
                        state_d = ACT_JUMP;
                        vy_use  = JUMP_V;
                    end else if (key_a || key_d) begin
                        state_d = ACT_WALK;
                    end else begin
                        state_d = ACT_IDLE;
                    end
                end
                ACT_JUMP: begin
                    if (!vy_q[9]) begin
                        state_d = ACT_FALL;
                    end else if (w_edge) begin
                        state_d = ACT_FLOAT;
                        vy_use  = FLOAT_LIFT;
                    end
                end
                ACT_FALL: begin
                    if (w_edge) begin
                        state_d = ACT_FLOAT;
                        vy_use  = FLOAT_LIFT;
                    end
                end
                ACT_FLOAT: begin
                    vy_use = w_edge ? FLOAT_LIFT : FLOAT_FALL;
                end
                ACT_INHALE: begin
                    cnt_d = cnt_inc;
                    if ((cnt_inc >= INHALE_MIN) && !key_j) begin
                        state_d = ACT_IDLE;
                    end
                end
                default: state_d = ACT_IDLE;
            endcase

            // Vertical step uses the velocity chosen for this tick (so the
            // take-off frame already moves by JUMP_V); float has no gravity.
            if (is_airborne(state_d)) begin
                y_sum = $signed({1'b0, y_q}) + $signed({vy_use[9], vy_use});
                if (state_d == ACT_FLOAT) begin
                    vy_d = vy_use;
                end else begin
                    vy_d = (vy_use >= MAX_FALL) ? MAX_FALL : vy_use + 10'sd1;
                end
                if (y_sum >= $signed({1'b0, c_y_ground})) begin
                    y_d     = c_y_ground;
                    vy_d    = 10'sd0;
                    state_d = ACT_IDLE;
                end else if (y_sum <= $signed({1'b0, c_y_top})) begin
                    y_d  = c_y_top;
                    vy_d = 10'sd0;
                end else begin
                    y_d = y_sum[9:0];
                end
            end

            if (state_d != state_q) begin
                div_d  = 4'd0;
                anim_d = 2'd0;
            end else if (div_q == ANIM_DIV - 4'd1) begin
                div_d  = 4'd0;
                anim_d = anim_q + 2'd1;
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q      <= DEF_START_X;
            y_q      <= c_y_ground;
            vy_q     <= 10'sd0;
            state_q  <= ACT_IDLE;
            facing_q <= 1'b0;
            anim_q   <= 2'd0;
            div_q    <= 4'd0;
            cnt_q    <= 6'd0;
            w_prev_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            state_q  <= state_d;
            facing_q <= facing_d;
            anim_q   <= anim_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            w_prev_q <= w_prev_d;
        end
    end

    assign kirby_x_o       = x_q;
    assign kirby_y_o       = y_q;
    assign action_o        = state_q;
    assign facing_left_o   = facing_q;
    assign anim_frame_o    = anim_q;
    assign inhale_active_o = (state_q == ACT_INHALE);

endmodule
`default_nettype wire

// File: tb/tb_kirby_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_kirby_action_ctrl
// Purpose: Self-checking bench for kirby_action_ctrl: fixed vector table,
//          hand-written corner sequences and randomized keys vs. a model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_kirby_action_ctrl;

    localparam int A_IDLE = 0, A_WALK = 1, A_JUMP = 2, A_FALL = 3, A_FLOAT = 4, A_INHALE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] kx, ky;
    logic [2:0] act;
    logic       face, inh;
    logic [1:0] anim;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_x, m_y, m_vy, m_act, m_face, m_anim, m_div, m_cnt;
    bit m_wprev;

    always #5 clk = ~clk;

    kirby_action_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .frame_clk_i     (frame_clk),
        .keycode_i       (keycode),
        .kirby_x_o       (kx),
        .kirby_y_o       (ky),
        .action_o        (act),
        .facing_left_o   (face),
        .anim_frame_o    (anim),
        .inhale_active_o (inh)
    );

    typedef struct {
        logic [7:0] key;
        int x;
        int y;
        int a;
        int f;
        int an;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 323; m_vy = 0; m_act = A_IDLE;
        m_face = 0; m_anim = 0; m_div = 0; m_cnt = 0; m_wprev = 0;
    endtask

    task automatic model_tick(input logic [7:0] k);
        bit ka, kd, kw, kj, we;
        int nxt;
        ka = (k == 8'h04); kd = (k == 8'h07); kw = (k == 8'h1A); kj = (k == 8'h0D);
        we = kw && !m_wprev;
        m_wprev = kw;
        if (m_act != A_INHALE) begin
            if (ka) begin m_x = (m_x - 1 < 207) ? 207 : m_x - 1; m_face = 1; end
            else if (kd) begin m_x = (m_x + 1 > 432) ? 432 : m_x + 1; m_face = 0; end
        end
        nxt = m_act;
        case (m_act)
            A_IDLE, A_WALK:
                if (kj) begin nxt = A_INHALE; m_cnt = 0; end
                else if (we) begin nxt = A_JUMP; m_vy = -6; end
                else nxt = (ka || kd) ? A_WALK : A_IDLE;
            A_JUMP:  if (m_vy >= 0) nxt = A_FALL; else if (we) nxt = A_FLOAT;
            A_FALL:  if (we) nxt = A_FLOAT;
            A_INHALE: begin
                m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
                if (m_cnt >= 8 && !kj) nxt = A_IDLE;
            end
            default: ;
        endcase
        if (nxt == A_FLOAT) m_vy = we ? -2 : 1;
        if (nxt == A_JUMP || nxt == A_FALL || nxt == A_FLOAT) begin
            m_y = m_y + m_vy;
            if (nxt != A_FLOAT) m_vy = (m_vy + 1 > 4) ? 4 : m_vy + 1;
            if (m_y >= 323) begin m_y = 323; m_vy = 0; nxt = A_IDLE; end
            else if (m_y <= 156) begin m_y = 156; m_vy = 0; end
        end
        if (nxt != m_act) begin m_div = 0; m_anim = 0; end
        else if (m_div == 5) begin m_div = 0; m_anim = (m_anim + 1) % 4; end
        else m_div++;
        m_act = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, 32'(kx), m_x);
        chk({tag, ".y"}, 32'(ky), m_y);
        chk({tag, ".act"}, 32'(act), m_act);
        chk({tag, ".face"}, 32'(face), m_face);
        chk({tag, ".anim"}, 32'(anim), m_anim);
        chk({tag, ".inh"}, 32'(inh), (m_act == A_INHALE) ? 1 : 0);
    endtask

    // One frame: raise frame_clk with the key present, let the update land.
    task automatic do_tick(input logic [7:0] k);
        @(negedge clk);
        keycode   = k;
        frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        model_tick(k);
    endtask

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{8'h07, 321, 323, A_WALK, 0, 0};
        tbl[1]  = '{8'h07, 322, 323, A_WALK, 0, 0};
        tbl[2]  = '{8'h07, 323, 323, A_WALK, 0, 0};
        tbl[3]  = '{8'h07, 324, 323, A_WALK, 0, 0};
        tbl[4]  = '{8'h07, 325, 323, A_WALK, 0, 0};
        tbl[5]  = '{8'h04, 324, 323, A_WALK, 1, 0};
        tbl[6]  = '{8'h00, 324, 323, A_IDLE, 1, 0};
        tbl[7]  = '{8'h1A, 324, 317, A_JUMP, 1, 0};
        tbl[8]  = '{8'h00, 324, 312, A_JUMP, 1, 0};
        tbl[9]  = '{8'h00, 324, 308, A_JUMP, 1, 0};
        tbl[10] = '{8'h00, 324, 305, A_JUMP, 1, 0};
        tbl[11] = '{8'h00, 324, 303, A_JUMP, 1, 0};
        tbl[12] = '{8'h00, 324, 302, A_JUMP, 1, 0};
        tbl[13] = '{8'h00, 324, 302, A_FALL, 1, 0};
        tbl[14] = '{8'h00, 324, 303, A_FALL, 1, 0};
        tbl[15] = '{8'h00, 324, 305, A_FALL, 1, 0};
        tbl[16] = '{8'h00, 324, 308, A_FALL, 1, 0};
        tbl[17] = '{8'h00, 324, 312, A_FALL, 1, 0};
        tbl[18] = '{8'h00, 324, 316, A_FALL, 1, 0};
        tbl[19] = '{8'h00, 324, 320, A_FALL, 1, 1};
        tbl[20] = '{8'h00, 324, 323, A_IDLE, 1, 0};

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.x", 32'(kx), 320);
        chk("rst.y", 32'(ky), 323);
        chk("rst.act", 32'(act), A_IDLE);
        chk("rst.face", 32'(face), 0);
        chk("rst.anim", 32'(anim), 0);

        for (int i = 0; i < 3; i++) do_tick(8'h00);
        check_all("idle3");

        // Walk, turn, jump arc and landing from the vector table.
        for (int i = 0; i < 21; i++) begin
            do_tick(tbl[i].key);
            chk($sformatf("tbl%0d.x", i), 32'(kx), tbl[i].x);
            chk($sformatf("tbl%0d.y", i), 32'(ky), tbl[i].y);
            chk($sformatf("tbl%0d.act", i), 32'(act), tbl[i].a);
            chk($sformatf("tbl%0d.face", i), 32'(face), tbl[i].f);
            chk($sformatf("tbl%0d.anim", i), 32'(anim), tbl[i].an);
        end

        // Two-clock latency and hold between ticks.
        @(negedge clk);
        keycode = 8'h07;
        frame_clk = 1'b1;
        @(posedge clk); #1;
        chk("lat1.x", 32'(kx), 324);
        @(posedge clk); #1;
        chk("lat2.x", 32'(kx), 325);
        @(negedge clk); frame_clk = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold.x", 32'(kx), 325);
        model_tick(8'h07);
        check_all("lat");

        // W held through the jump gives no float; a fresh press does.
        do_tick(8'h00);
        do_tick(8'h1A); do_tick(8'h1A); do_tick(8'h1A);
        chk("hold_w.act", 32'(act), A_JUMP);
        chk("hold_w.y", 32'(ky), 308);
        do_tick(8'h00);
        do_tick(8'h1A);
        chk("float.act", 32'(act), A_FLOAT);
        chk("float.y0", 32'(ky), 303);
        do_tick(8'h00);
        chk("float.y1", 32'(ky), 304);
        do_tick(8'h00);
        chk("float.y2", 32'(ky), 305);
        do_tick(8'h1A);
        chk("flap.y", 32'(ky), 303);
        for (int i = 0; i < 25; i++) do_tick(8'h00);
        chk("float_land.y", 32'(ky), 323);
        chk("float_land.act", 32'(act), A_IDLE);

        // Inhale minimum duration, x and facing frozen.
        for (int i = 0; i < 3; i++) do_tick(8'h0D);
        chk("inh3.act", 32'(act), A_INHALE);
        for (int i = 0; i < 5; i++) do_tick(8'h04);
        chk("inh8.act", 32'(act), A_INHALE);
        chk("inh8.active", 32'(inh), 1);
        chk("inh8.x", 32'(kx), 325);
        chk("inh8.face", 32'(face), 0);
        do_tick(8'h04);
        chk("inh9.act", 32'(act), A_IDLE);
        chk("inh9.active", 32'(inh), 0);
        chk("inh9.x", 32'(kx), 325);
        do_tick(8'h04);
        chk("inh10.x", 32'(kx), 324);
        chk("inh10.face", 32'(face), 1);

        // Right-edge saturation.
        for (int i = 0; i < 200; i++) do_tick(8'h07);
        chk("sat.x", 32'(kx), 432);
        check_all("sat");

        // Mid-air reset landing on the same clock as a tick.
        do_tick(8'h1A);
        chk("air.y", 32'(ky), 317);
        @(negedge clk);
        keycode = 8'h07;
        frame_clk = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_clk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("rst_tick");

        // Randomized key stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] k;
            case ($urandom_range(0, 9))
                1, 2:    k = 8'h04;
                3, 4:    k = 8'h07;
                5, 6:    k = 8'h1A;
                7:       k = 8'h0D;
                8:       k = 8'h55;
                default: k = 8'h00;
            endcase
            do_tick(k);
            check_all($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
